// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the display scan controller
package disp_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [2:0] DIG_S1  = 3'd0;
   localparam logic [2:0] DIG_S10 = 3'd1;
   localparam logic [2:0] DIG_M1  = 3'd2;
   localparam logic [2:0] DIG_M10 = 3'd3;
   localparam logic [2:0] DIG_H1  = 3'd4;
   localparam logic [2:0] DIG_H10 = 3'd5;

   localparam logic FIELD_MIN  = 1'b0;
   localparam logic FIELD_HOUR = 1'b1;

   // Separator dots sit on the ones digit of minutes and hours.
   localparam logic [5:0] DP_MASK = 6'b010100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

   typedef struct packed {
      logic [5:0] h;
      logic [5:0] m;
      logic [5:0] s;
   } hms_t;

   function automatic logic field_hit(input logic [2:0] idx, input logic sel);
      if (sel == FIELD_HOUR) begin
         return (idx == DIG_H1) || (idx == DIG_H10);
      end
      return (idx == DIG_M1) || (idx == DIG_M10);
   endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - shared digit bus towards the 7-segment driver
interface disp_scan_ctrl_if;

   logic [5:0] digit_sel;
   logic [3:0] seg_bcd;
   logic       seg_dp;
   logic       frame_done;

   modport master (
      output digit_sel,
      output seg_bcd,
      output seg_dp,
      output frame_done
   );

   modport slave (
      input digit_sel,
      input seg_bcd,
      input seg_dp,
      input frame_done
   );

endinterface

// File: rtl/disp_scan_ctrl_bin2bcd6.sv
// rtl/disp_scan_ctrl_bin2bcd6.sv - 6-bit binary to two-digit BCD split, unclamped
module bin2bcd6 (
   input  logic [5:0] bin,
   output logic [2:0] tens,
   output logic [3:0] ones
);

   logic [5:0] quot;
   logic [5:0] rem;

   assign quot = bin / 6'd10;
   assign rem  = bin % 6'd10;
   assign tens = quot[2:0];
   assign ones = rem[3:0];

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - six-digit H:M:S scan scheduler with per-frame snapshot
// and field/alarm blinking on a shared BCD digit bus.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_FRAMES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [5:0]       in_h,
   input  logic [5:0]       in_m,
   input  logic [5:0]       in_s,
   input  logic             blink_en,
   input  logic             blink_sel,
   input  logic             alarming,
   disp_scan_ctrl_if.master disp
);

   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   scan_state_e      state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   hms_t             snap_q, snap_d;
   logic [5:0]       digit_sel_q, digit_sel_d;
   logic [3:0]       seg_bcd_q, seg_bcd_d;
   logic             seg_dp_q, seg_dp_d;
   logic             frame_done_q, frame_done_d;

   logic             pre_last;
   logic             frame_wrap;
   logic             load_snap;
   logic             step;
   logic             blank;
   logic [3:0]       digit_val;
   logic [2:0]       tens_h, tens_m, tens_s;
   logic [3:0]       ones_h, ones_m, ones_s;

   assign pre_last   = (pre_q == PRE_LAST);
   assign frame_wrap = pre_last && (idx_q == DIG_H10);

   // The snapshot is taken at scan start and at every frame wrap, so digit 0
   // of a new frame is already decoded from the freshly captured inputs.
   assign load_snap = en && ((state_q == ST_IDLE) || ((state_q == ST_SCAN) && frame_wrap));
   assign snap_d    = load_snap ? {in_h, in_m, in_s} : snap_q;

   bin2bcd6 u_bcd_h (.bin(snap_d.h), .tens(tens_h), .ones(ones_h));
   bin2bcd6 u_bcd_m (.bin(snap_d.m), .tens(tens_m), .ones(ones_m));
   bin2bcd6 u_bcd_s (.bin(snap_d.s), .tens(tens_s), .ones(ones_s));

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      pre_d         = pre_q;
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      digit_sel_d   = digit_sel_q;
      seg_bcd_d     = seg_bcd_q;
      seg_dp_d      = seg_dp_q;
      frame_done_d  = 1'b0;
      step          = 1'b0;
      digit_val     = 4'd0;
      blank         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            digit_sel_d = '0;
            seg_bcd_d   = '0;
            seg_dp_d    = 1'b0;
            if (en) begin
               state_d = ST_SCAN;
               idx_d   = DIG_S1;
               pre_d   = '0;
               step    = 1'b1;
            end
         end
         ST_SCAN: begin
            if (!en) begin
               state_d       = ST_IDLE;
               idx_d         = DIG_S1;
               pre_d         = '0;
               frame_cnt_d   = '0;
               blink_phase_d = 1'b0;
               digit_sel_d   = '0;
               seg_bcd_d     = '0;
               seg_dp_d      = 1'b0;
            end else if (pre_last) begin
               pre_d = '0;
               step  = 1'b1;
               if (idx_q == DIG_H10) begin
                  idx_d        = DIG_S1;
                  frame_done_d = 1'b1;
                  if (frame_cnt_q == FRM_LAST) begin
                     frame_cnt_d   = '0;
                     blink_phase_d = ~blink_phase_q;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (idx_d)
         DIG_S1:  digit_val = ones_s;
         DIG_S10: digit_val = {1'b0, tens_s};
         DIG_M1:  digit_val = ones_m;
         DIG_M10: digit_val = {1'b0, tens_m};
         DIG_H1:  digit_val = ones_h;
         DIG_H10: digit_val = {1'b0, tens_h};
         default: digit_val = 4'd0;
      endcase

      // Blanking gates only the enable and dot; the BCD value keeps flowing.
      blank = blink_phase_d && (alarming || (blink_en && field_hit(idx_d, blink_sel)));

      if (step) begin
         digit_sel_d = blank ? 6'b000000 : (6'b000001 << idx_d);
         seg_bcd_d   = digit_val;
         seg_dp_d    = !blank && DP_MASK[idx_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         pre_q         <= '0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         snap_q        <= '0;
         digit_sel_q   <= '0;
         seg_bcd_q     <= '0;
         seg_dp_q      <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pre_q         <= pre_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         snap_q        <= snap_d;
         digit_sel_q   <= digit_sel_d;
         seg_bcd_q     <= seg_bcd_d;
         seg_dp_q      <= seg_dp_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign disp.digit_sel  = digit_sel_q;
   assign disp.seg_bcd    = seg_bcd_q;
   assign disp.seg_dp     = seg_dp_q;
   assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - directed checks of disp_scan_ctrl (SCAN_DIV=4, BLINK_FRAMES=2)
module tb_disp_scan_ctrl;

   typedef struct {
      logic [5:0]  h;
      logic [5:0]  m;
      logic [5:0]  s;
      logic        blink_en;
      logic        blink_sel;
      logic        alarming;
      logic [23:0] digs;
      logic [5:0]  blank_mask;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic [5:0] in_h, in_m, in_s;
   logic       blink_en, blink_sel, alarming;

   int n_cmp  = 0;
   int n_fail = 0;

   disp_scan_ctrl_if disp_bus ();

   disp_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_h      (in_h),
      .in_m      (in_m),
      .in_s      (in_s),
      .blink_en  (blink_en),
      .blink_sel (blink_sel),
      .alarming  (alarming),
      .disp      (disp_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_blank_out(input string name);
      check({name, " digit_sel"}, 32'(disp_bus.digit_sel), 32'd0);
      check({name, " seg_bcd"}, 32'(disp_bus.seg_bcd), 32'd0);
      check({name, " seg_dp"}, 32'(disp_bus.seg_dp), 32'd0);
      check({name, " frame_done"}, 32'(disp_bus.frame_done), 32'd0);
   endtask

   // Leaves the bench just after the releasing negedge; the next negedge is cycle 0.
   task automatic start(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                        input logic be, input logic bs, input logic al);
      @(negedge clk);
      reset     = 1'b1;
      en        = 1'b0;
      in_h      = h;
      in_m      = m;
      in_s      = s;
      blink_en  = be;
      blink_sel = bs;
      alarming  = al;
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
   endtask

   vec_t        vecs[6];
   logic [5:0]  dp_mask;
   logic [23:0] seq63;

   initial begin
      vecs[0] = '{h: 6'd12, m: 6'd34, s: 6'd56, blink_en: 1'b0, blink_sel: 1'b0, alarming: 1'b0,
                  digs: 24'h123456, blank_mask: 6'b000000};
      vecs[1] = '{h: 6'd12, m: 6'd34, s: 6'd56, blink_en: 1'b1, blink_sel: 1'b1, alarming: 1'b0,
                  digs: 24'h123456, blank_mask: 6'b110000};
      vecs[2] = '{h: 6'd12, m: 6'd34, s: 6'd56, blink_en: 1'b1, blink_sel: 1'b0, alarming: 1'b1,
                  digs: 24'h123456, blank_mask: 6'b111111};
      vecs[3] = '{h: 6'd63, m: 6'd63, s: 6'd63, blink_en: 1'b1, blink_sel: 1'b0, alarming: 1'b0,
                  digs: 24'h636363, blank_mask: 6'b001100};
      vecs[4] = '{h: 6'd9, m: 6'd50, s: 6'd0, blink_en: 1'b0, blink_sel: 1'b0, alarming: 1'b0,
                  digs: 24'h095000, blank_mask: 6'b000000};
      vecs[5] = '{h: 6'd9, m: 6'd50, s: 6'd0, blink_en: 1'b0, blink_sel: 1'b1, alarming: 1'b1,
                  digs: 24'h095000, blank_mask: 6'b111111};
      dp_mask = 6'b010100;
      seq63   = 24'h636363;

      reset = 1'b1; en = 1'b0;
      in_h = '0; in_m = '0; in_s = '0;
      blink_en = 1'b0; blink_sel = 1'b0; alarming = 1'b0;
      repeat (3) @(negedge clk);
      check_blank_out("reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_blank_out("idle en=0");

      for (int v = 0; v < 6; v++) begin
         start(vecs[v].h, vecs[v].m, vecs[v].s, vecs[v].blink_en, vecs[v].blink_sel, vecs[v].alarming);
         for (int c = 0; c < 144; c++) begin
            int         idx;
            logic       blank;
            logic [5:0] exp_sel;
            logic [3:0] exp_bcd;
            @(negedge clk);
            idx     = (c / 4) % 6;
            blank   = (((c / 24) / 2) % 2 == 1) && vecs[v].blank_mask[idx];
            exp_sel = blank ? 6'b000000 : (6'b000001 << idx);
            exp_bcd = vecs[v].digs[4*idx +: 4];
            check($sformatf("v%0d c%0d digit_sel", v, c), 32'(disp_bus.digit_sel), 32'(exp_sel));
            check($sformatf("v%0d c%0d seg_bcd", v, c), 32'(disp_bus.seg_bcd), 32'(exp_bcd));
            check($sformatf("v%0d c%0d seg_dp", v, c), 32'(disp_bus.seg_dp),
                  32'(!blank && dp_mask[idx]));
            check($sformatf("v%0d c%0d frame_done", v, c), 32'(disp_bus.frame_done),
                  32'((c % 24 == 0) && (c > 0)));
         end
      end

      // Mid-frame input change is held off until the next frame.
      start(6'd12, 6'd34, 6'd56, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         if (c == 12) check("snap c12 bcd", 32'(disp_bus.seg_bcd), 32'd3);
         if (c == 16) check("snap c16 bcd", 32'(disp_bus.seg_bcd), 32'd2);
         if (c == 20) check("snap c20 bcd", 32'(disp_bus.seg_bcd), 32'd1);
         if (c == 23) check("snap c23 frame_done", 32'(disp_bus.frame_done), 32'd0);
         if (c == 24) begin
            check("snap c24 bcd", 32'(disp_bus.seg_bcd), 32'd7);
            check("snap c24 frame_done", 32'(disp_bus.frame_done), 32'd1);
            check("snap c24 digit_sel", 32'(disp_bus.digit_sel), 32'd1);
         end
         if (c > 24 && c % 4 == 0) check($sformatf("snap c%0d bcd", c), 32'(disp_bus.seg_bcd), 32'd0);
         if (c == 10) begin
            in_h = 6'd0; in_m = 6'd0; in_s = 6'd7;
         end
      end

      // Drop en during idx 3 of a blanked alarm frame, then restart.
      start(6'd12, 6'd34, 6'd56, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 62; c++) begin
         @(negedge clk);
         if (c == 50) begin
            check("alarm c50 digit_sel", 32'(disp_bus.digit_sel), 32'd0);
            check("alarm c50 seg_bcd", 32'(disp_bus.seg_bcd), 32'd6);
         end
      end
      en = 1'b0;
      @(negedge clk);
      check_blank_out("en drop");
      @(negedge clk);
      check_blank_out("en low idle");
      en = 1'b1;
      for (int c = 0; c < 49; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("reen c0 digit_sel", 32'(disp_bus.digit_sel), 32'd1);
            check("reen c0 seg_bcd", 32'(disp_bus.seg_bcd), 32'd6);
            check("reen c0 frame_done", 32'(disp_bus.frame_done), 32'd0);
         end
         if (c == 4) check("reen c4 digit_sel", 32'(disp_bus.digit_sel), 32'd2);
         if (c == 24) begin
            check("reen c24 frame_done", 32'(disp_bus.frame_done), 32'd1);
            check("reen c24 digit_sel", 32'(disp_bus.digit_sel), 32'd1);
         end
         if (c == 48) check("reen c48 digit_sel", 32'(disp_bus.digit_sel), 32'd0);
      end

      // Asynchronous reset mid-frame, then a clean restart at idx 0.
      start(6'd63, 6'd63, 6'd63, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 14; c++) @(negedge clk);
      check("pre-reset digit_sel", 32'(disp_bus.digit_sel), 32'd8);
      reset = 1'b1;
      #1;
      check_blank_out("async reset");
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c % 4 == 0) begin
            check($sformatf("restart c%0d seg_bcd", c), 32'(disp_bus.seg_bcd),
                  32'(seq63[4*(c/4) +: 4]));
            check($sformatf("restart c%0d digit_sel", c), 32'(disp_bus.digit_sel),
                  32'(6'b000001 << (c / 4)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan scheduler for the six-digit H:M:S display. It shares one BCD digit bus (seg_bcd/seg_dp) among six digit enables. The block takes the h/m/s values selected by the display mux and splits them into tens/ones. It sequences the digits, takes a coherent snapshot per frame, and blinks the field being edited or the whole display while the alarm rings. It sits between the display mux and the board's 7-segment driver.

Parameters:
SCAN_DIV, 4, clk cycles each digit is driven (>=1)
BLINK_FRAMES, 2, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 blanks the display and holds the scheduler idle
in_h  in  6  hours value, binary 0..63
in_m  in  6  minutes value, binary 0..63
in_s  in  6  seconds value, binary 0..63
blink_en  in  1  blink the field chosen by blink_sel (set modes)
blink_sel  in  1  field to blink: 0 = minutes, 1 = hours
alarming  in  1  blink all six digits
digit_sel  out  6  one-hot active-high digit enable; bit k = digit index k
seg_bcd  out  4  BCD value of the driven digit
seg_dp  out  1  separator dot for the driven digit
frame_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Clock/reset: clk; reset is asynchronous, active-high.
- Reset values: digit_sel=0, seg_bcd=0, seg_dp=0, frame_done=0. Internal state also resets: idx=0, prescaler=0, frame_cnt=0, blink_phase=0, snapshot=0, state=IDLE.
- Digit map: idx0=s ones, 1=s tens, 2=m ones, 3=m tens, 4=h ones, 5=h tens.
- BCD split: tens=v/10 (0..6), ones=v%10. There is no clamping; 63 -> tens 6, ones 3.
- seg_dp=1 on idx 2 and idx 4 (field separators) whenever that digit is not blanked.
- FSM states: IDLE, SCAN.
- IDLE -> SCAN on the first edge with en=1. At that edge: load snapshot from in_h/m/s, set idx=0, prescaler=0, and register outputs for digit 0. All outputs are registered, so digit 0 is visible right after that edge.
- SCAN, prescaler: increments each cycle. When prescaler = SCAN_DIV-1, it resets to 0 and idx advances to idx+1. Each digit is therefore driven for exactly SCAN_DIV cycles.
- SCAN, frame wrap (idx 5 -> 0), all at the same edge:
  - frame_done=1 for one cycle;
  - snapshot reloads from the current in_*, and digit 0 shows the new values;
  - frame_cnt increments; when frame_cnt reaches BLINK_FRAMES-1, it clears to 0 and blink_phase toggles.
- Input timing: in_* changes mid-frame do not affect the current frame. blink_en, blink_sel and alarming are not snapshotted; they take effect at the next digit update.
- Blanking when blink_phase=1:
  - alarming=1 -> digit_sel=0 and seg_dp=0 for every digit;
  - else blink_en=1 -> the same blanking applies only to the selected field's digits (idx 2,3 or 4,5).
- While blanked, seg_bcd is still driven with the digit value, and idx/prescaler keep advancing.
- alarming takes priority over blink_en.
- en=0 in SCAN: at the next edge return to IDLE. All outputs go to their reset values, and idx, prescaler, frame_cnt and blink_phase clear. frame_done is not pulsed.
- Reset mid-frame: outputs drop immediately (asynchronous); the scan restarts at digit 0 after en is seen high.

Decomposition:
- Shared package disp_pkg: digit-index constants (DIG_S1..DIG_H10), field codes (FIELD_MIN=0, FIELD_HOUR=1), DP mask (6'b010100).
- One combinational sub-module, bin2bcd6 (6-bit -> tens[2:0], ones[3:0]), instantiated three times on the snapshot.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2; one frame = 24 cycles):
1. Reset, en=1, in=12:34:56 -> seg_bcd 6,5,4,3,2,1, each held 4 cycles. digit_sel 000001..100000; seg_dp=1 only with 000100/010000. frame_done pulses exactly at cycle 24, then the pattern repeats.
2. At cycle 10, change in to 00:00:07 -> the rest of frame 0 still shows 3,2,1. Frame 1 shows 7,0,0,0,0,0.
3. blink_en=1, blink_sel=1 -> frames 0-1 unblanked. In frames 2-3, digit_sel=0 during idx 4,5 while seg_bcd still shows 2,1. Frames 4-5 unblanked again.
4. alarming=1 with blink_en=1, blink_sel=0 -> frames 2-3: digit_sel=0 and seg_dp=0 on all six digits. Frames 0-1 and 4-5: full display.
5. Drop en during idx 3 -> next edge: digit_sel=0, seg_bcd=0, no frame_done. Re-raise en -> digit 0 on the first edge, blink_phase=0.
6. in=63:63:63, assert reset at cycle 13 -> outputs go to 0 immediately. After release with en=1, the scan restarts at idx0: sequence 3,6,3,6,3,6.
